apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

APB3-style master that converts a simple single-outstanding host request/response interface into APB SETUP/ACCESS transfers to up to NUM_SLAVES peripherals (APB_GPO, GPI, UART, …). Sits directly upstream of the APB slave interfaces: drives the shared PADDR/PWRITE/PWDATA/PENABLE and one-hot PSEL, and muxes back the selected slave's PREADY/PRDATA. Adds address decode and an ACCESS-phase timeout so a dead slave cannot hang the host.

## Interface
- NUM_SLAVES, 4 — number of PSEL lines (≥1, ≤16)
- BASE_HI, 16'h1000 — required value of addr[31:16]
- TIMEOUT, 16 — maximum ACCESS cycles without PREADY before abort
- PCLK  in  1  — sole clock, all logic rising-edge
- PRESET  in  1  — reset, asynchronous assert, active-low (0 = reset)
- req_valid  in  1  — host request valid
- req_ready  out  1  — high exactly when state = IDLE
- req_write  in  1  — 1 write, 0 read
- req_addr  in  32  — byte address
- req_wdata  in  32  — write data
- rsp_valid  out  1  — one-cycle response pulse
- rsp_rdata  out  32  — read data (0 on writes and errors)
- rsp_err  out  1  — decode miss or timeout, qualified by rsp_valid
- PADDR  out  32  — APB address (slaves slice low bits)
- PWRITE  out  1 ; PWDATA  out  32 ; PENABLE  out  1
- PSEL  out  NUM_SLAVES  — one-hot select
- PREADY  in  NUM_SLAVES  — per-slave ready
- PRDATA  in  32 x NUM_SLAVES (unpacked)  — per-slave read data

## Operation
- Decode: hit iff req_addr[31:16]==BASE_HI and idx=req_addr[15:12] < NUM_SLAVES; slave = idx.
- FSM states IDLE, SETUP, ACCESS.
- IDLE: on req_valid (req_ready=1): hit → latch addr/write/wdata/idx onto PADDR/PWRITE/PWDATA, go SETUP; miss → stay IDLE, next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0, no PSEL.
- SETUP: PSEL[idx]=1, PENABLE=0; unconditionally → ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1; timeout counter increments each cycle. PREADY[idx]=1 → IDLE, rsp_valid, rsp_err=0, rsp_rdata = PWRITE ? 0 : PRDATA[idx]. Counter reaches TIMEOUT with PREADY low → IDLE, rsp_err=1, rsp_rdata=0.
- Only PREADY/PRDATA of the selected slave are observed; others ignored.
- PADDR/PWRITE/PWDATA stable from SETUP through last ACCESS cycle; retain last value in IDLE.
- Requests while not IDLE are not accepted (req_ready=0); host must hold req_valid.
- No back-to-back: at least one IDLE cycle between transfers.

## Timing
- Reset (PRESET=0): state IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0; req_ready=1. Reset mid-transfer aborts immediately, no response generated.
- Accept at edge 0 → cycle 1 SETUP, cycle 2 ACCESS; slave with registered PREADY (GPO style) raises PREADY in cycle 3 → rsp_valid in cycle 4 with req_ready=1. Zero-wait slave: rsp_valid in cycle 3.
- Decode miss: rsp_valid in the cycle after acceptance.
- Timeout: rsp_valid after exactly TIMEOUT ACCESS cycles; counter width $clog2(TIMEOUT+1), cleared on entering ACCESS.
- PREADY and timeout in the same cycle: PREADY wins (no error).
- rsp_* are registered; rsp_valid is a single-cycle pulse.

## Structure
- Shared package apb_pkg: state enum (IDLE, SETUP, ACCESS), APB_ADDR_W=32, APB_DATA_W=32.
- Sub-module apb_addr_decoder: combinational req_addr → hit, idx, one-hot sel.

## Test plan
- Write 0x1000_0000 ← 0xF (slave 0 = GPO) → PSEL=0001 cycles 1–3, PENABLE cycles 2–3, PWDATA=0xF; rsp_valid cycle 4, rsp_err=0; GPO mode=0xF.
- Write 0x1000_0004 ← 0x5, then read 0x1000_0004 → rsp_rdata=0x0000_0005, rsp_err=0.
- Read 0x2000_0000 and 0x1000_5000 (idx 5 ≥ 4) → rsp_valid next cycle, rsp_err=1, rdata=0, PSEL stays 0.
- Slave 2 ties PREADY=0, access 0x1000_2000 → exactly 16 ACCESS cycles, rsp_err=1, then req_ready=1; PREADY raised on cycle 16 → rsp_err=0.
- Wrong-slave PREADY: slave 1 PREADY=1 while accessing slave 3 with wait states → ignored, completes only on PREADY[3].
- PRESET low during ACCESS → PSEL/PENABLE 0 asynchronously, no rsp_valid, next request completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB bridge types and widths
// Purpose: FSM state encoding and bus widths used by the APB master bridge
//          and its address decoder.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - combinational host address to APB slave decode
// Purpose: decides whether a host address targets one of the APB slaves.
// Ports:
//   req_page  in  20          address bits [31:12] of the host request
//   hit       out 1           address is in the bridge window and idx < NUM_SLAVES
//   sel       out NUM_SLAVES  one-hot slave select, all zero on a miss
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [15:0] BASE_HI    = 16'h1000
) (
  input  logic [APB_ADDR_W-13:0] req_page,
  output logic                   hit,
  output logic [NUM_SLAVES-1:0]  sel
);

  localparam logic [4:0] NUM_SLAVES_W = 5'(NUM_SLAVES);

  logic [3:0] w_idx;

  assign w_idx = req_page[3:0];

  // Extra top bit on the compare keeps NUM_SLAVES=16 representable.
  assign hit = (req_page[19:4] == BASE_HI) && ({1'b0, w_idx} < NUM_SLAVES_W);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = hit && (w_idx == 4'(i));
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding host to APB3 master bridge
// Purpose: turns host requests into APB SETUP/ACCESS transfers, decodes the
//          target slave, and aborts an ACCESS phase that exceeds TIMEOUT cycles.
// Ports:
//   PCLK, PRESET                 clock, async active-low reset
//   req_valid/ready/write/addr/wdata   host request (accepted only in IDLE)
//   rsp_valid/rdata/err          registered one-cycle host response
//   PADDR/PWRITE/PWDATA/PENABLE  shared APB request signals
//   PSEL                         one-hot slave select
//   PREADY/PRDATA                per-slave ready and read data
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [15:0] BASE_HI    = 16'h1000,
  parameter int          TIMEOUT    = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [APB_ADDR_W-1:0]  req_addr,
  input  logic [APB_DATA_W-1:0]  req_wdata,
  output logic                   rsp_valid,
  output logic [APB_DATA_W-1:0]  rsp_rdata,
  output logic                   rsp_err,
  output logic [APB_ADDR_W-1:0]  PADDR,
  output logic                   PWRITE,
  output logic [APB_DATA_W-1:0]  PWDATA,
  output logic                   PENABLE,
  output logic [NUM_SLAVES-1:0]  PSEL,
  input  logic [NUM_SLAVES-1:0]  PREADY,
  input  logic [APB_DATA_W-1:0]  PRDATA [NUM_SLAVES]
);

  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  apb_state_e              r_state;
  apb_state_e              w_state_next;
  logic [NUM_SLAVES-1:0]   r_sel;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    w_hit;
  logic [NUM_SLAVES-1:0]   w_sel;
  logic                    w_pready;
  logic                    w_timeout;
  logic [APB_DATA_W-1:0]   w_prdata;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_HI    (BASE_HI)
  ) u_decoder (
    .req_page (req_addr[APB_ADDR_W-1:12]),
    .hit      (w_hit),
    .sel      (w_sel)
  );

  // Only the latched slave's PREADY/PRDATA are visible; the rest are masked.
  always_comb begin
    w_pready = |(PREADY & r_sel);
    w_prdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_prdata = w_prdata | (PRDATA[i] & {APB_DATA_W{r_sel[i]}});
    end
  end

  // r_cnt holds ACCESS cycles already completed; w_cnt_inc includes this one.
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (r_state == ACCESS) && (w_cnt_inc == CNT_LIMIT);

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    PSEL         = '0;
    PENABLE      = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && w_hit) begin
          w_state_next = SETUP;
        end
      end
      SETUP: begin
        PSEL         = r_sel;
        w_state_next = ACCESS;
      end
      ACCESS: begin
        PSEL    = r_sel;
        PENABLE = 1'b1;
        if (w_pready || w_timeout) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      r_sel     <= '0;
      r_cnt     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (w_hit) begin
              PADDR  <= req_addr;
              PWRITE <= req_write;
              PWDATA <= req_wdata;
              r_sel  <= w_sel;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end
        SETUP: r_cnt <= '0;
        ACCESS: begin
          r_cnt <= w_cnt_inc;
          if (w_pready) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : w_prdata;
          end else if (w_timeout) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking bench for apb_master_bridge
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int NS = 4;

  logic                PCLK = 1'b0;
  logic                PRESET;
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [31:0]         req_addr;
  logic [31:0]         req_wdata;
  logic                rsp_valid;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic [31:0]         PADDR;
  logic                PWRITE;
  logic [31:0]         PWDATA;
  logic                PENABLE;
  logic [NS-1:0]       PSEL;
  logic [NS-1:0]       PREADY;
  logic [31:0]         PRDATA [NS];

  logic [NS-1:1]       rdy_cfg;
  logic                s0_ready;
  logic [31:0]         s0_regs [4];

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .NUM_SLAVES (NS),
    .BASE_HI    (16'h1000),
    .TIMEOUT    (16)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PENABLE   (PENABLE),
    .PSEL      (PSEL),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA)
  );

  // Slave 0: GPO-style register slave with one registered wait state.
  always @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      s0_ready <= 1'b0;
    end else begin
      s0_ready <= PSEL[0] && PENABLE && !s0_ready;
      if (PSEL[0] && PENABLE && s0_ready && PWRITE) s0_regs[PADDR[3:2]] <= PWDATA;
    end
  end

  assign PREADY    = {rdy_cfg, s0_ready};
  assign PRDATA[0] = s0_regs[PADDR[3:2]];
  assign PRDATA[1] = 32'hA1A1_0001;
  assign PRDATA[2] = 32'hB2B2_0002;
  assign PRDATA[3] = 32'hC3C3_0003;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[12];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat_seen;
  int          ena_cnt;
  bit          psel_seen;
  logic [NS-1:0] psel_tr [64];
  logic        pen_tr [64];
  logic [31:0] pwdata_tr [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge: pops the scoreboard whenever the DUT responds.
  task automatic sample_rsp();
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 want 0");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] erdata, input bit eerr,
                      input int raise_at, input int raise_idx);
    @(negedge PCLK);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    sb_q.push_back('{erdata, eerr});
    @(posedge PCLK);
    #1;
    req_valid = 1'b0;
    lat_seen  = 0;
    ena_cnt   = 0;
    psel_seen = 1'b0;
    for (int c = 1; c <= 40 && lat_seen == 0; c++) begin
      if (c == raise_at) rdy_cfg[raise_idx] = 1'b1;
      @(negedge PCLK);
      psel_tr[c]   = PSEL;
      pen_tr[c]    = PENABLE;
      pwdata_tr[c] = PWDATA;
      if (PSEL != '0) psel_seen = 1'b1;
      if (PENABLE) ena_cnt++;
      if (rsp_valid === 1'b1) begin
        lat_seen = c;
        check("req_ready_at_rsp", 32'(req_ready), 32'd1);
      end
      sample_rsp();
      if (lat_seen == 0) begin
        @(posedge PCLK);
        #1;
      end
    end
    if (lat_seen == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_wait: got no rsp_valid in 40 cycles want one");
      sb_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h1000_0000, 32'h0000_000F, 32'h0,          1'b0, 4};
    vecs[1]  = '{1'b1, 32'h1000_0004, 32'h0000_0005, 32'h0,          1'b0, 4};
    vecs[2]  = '{1'b0, 32'h1000_0004, 32'h0,         32'h0000_0005, 1'b0, 4};
    vecs[3]  = '{1'b0, 32'h1000_0000, 32'h0,         32'h0000_000F, 1'b0, 4};
    vecs[4]  = '{1'b0, 32'h2000_0000, 32'h0,         32'h0,          1'b1, 1};
    vecs[5]  = '{1'b0, 32'h1000_5000, 32'h0,         32'h0,          1'b1, 1};
    vecs[6]  = '{1'b0, 32'h1000_1000, 32'h0,         32'hA1A1_0001, 1'b0, 3};
    vecs[7]  = '{1'b1, 32'h1000_1008, 32'h1234_5678, 32'h0,          1'b0, 3};
    vecs[8]  = '{1'b0, 32'h1000_3000, 32'h0,         32'hC3C3_0003, 1'b0, 3};
    vecs[9]  = '{1'b0, 32'h1000_2000, 32'h0,         32'h0,          1'b1, 18};
    vecs[10] = '{1'b1, 32'h1000_F000, 32'hDEAD_BEEF, 32'h0,          1'b1, 1};
    vecs[11] = '{1'b0, 32'h1001_0000, 32'h0,         32'h0,          1'b1, 1};

    PRESET    = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rdy_cfg   = 3'b101;

    // Reset state
    repeat (3) @(negedge PCLK);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_psel",      32'(PSEL), 32'd0);
    check("rst_penable",   32'(PENABLE), 32'd0);
    check("rst_paddr",     PADDR, 32'd0);
    check("rst_pwrite",    32'(PWRITE), 32'd0);
    check("rst_pwdata",    PWDATA, 32'd0);
    check("rst_rsp",       {rsp_rdata[29:0], rsp_valid, rsp_err}, 32'd0);
    PRESET = 1'b1;

    // GPO write waveform: PSEL cycles 1-3, PENABLE cycles 2-3, response cycle 4
    xfer(1'b1, 32'h1000_0000, 32'h0000_000F, 32'h0, 1'b0, 0, 1);
    check("gpo_lat", 32'(lat_seen), 32'd4);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("gpo_psel_c%0d", c), 32'(psel_tr[c]), (c <= 3) ? 32'd1 : 32'd0);
      check($sformatf("gpo_pen_c%0d", c), 32'(pen_tr[c]), (c == 2 || c == 3) ? 32'd1 : 32'd0);
      check($sformatf("gpo_pwdata_c%0d", c), pwdata_tr[c], 32'h0000_000F);
    end
    check("gpo_mode", s0_regs[0], 32'h0000_000F);

    // Table of single transfers
    for (int i = 0; i < 12; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, 0, 1);
      check($sformatf("v%0d_lat", i), 32'(lat_seen), 32'(vecs[i].lat));
      check($sformatf("v%0d_psel_seen", i), 32'(psel_seen), 32'(vecs[i].lat > 1));
      check($sformatf("v%0d_access_cycles", i), 32'(ena_cnt),
            (vecs[i].lat > 1) ? 32'(vecs[i].lat - 2) : 32'd0);
    end

    // PREADY arriving on the 16th ACCESS cycle beats the timeout
    rdy_cfg[2] = 1'b0;
    xfer(1'b0, 32'h1000_2000, 32'h0, 32'hB2B2_0002, 1'b0, 17, 2);
    check("edge_to_lat", 32'(lat_seen), 32'd18);
    check("edge_to_access_cycles", 32'(ena_cnt), 32'd16);
    rdy_cfg[2] = 1'b0;

    // PREADY from slave 1 must be ignored while slave 3 is selected
    rdy_cfg[1] = 1'b1;
    rdy_cfg[3] = 1'b0;
    xfer(1'b0, 32'h1000_3000, 32'h0, 32'hC3C3_0003, 1'b0, 6, 3);
    check("wrong_slave_lat", 32'(lat_seen), 32'd7);
    check("wrong_slave_psel_c5", 32'(psel_tr[5]), 32'b1000);
    rdy_cfg[3] = 1'b1;

    // Reset during ACCESS aborts with no response
    @(negedge PCLK);
    req_write = 1'b0;
    req_addr  = 32'h1000_2000;
    req_valid = 1'b1;
    @(posedge PCLK);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    check("mid_rst_in_access", 32'(PENABLE), 32'd1);
    PRESET = 1'b0;
    #1;
    check("mid_rst_psel", 32'(PSEL), 32'd0);
    check("mid_rst_penable", 32'(PENABLE), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    PRESET = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge PCLK);
      sample_rsp();
    end
    xfer(1'b0, 32'h1000_1000, 32'h0, 32'hA1A1_0001, 1'b0, 0, 1);
    check("post_rst_lat", 32'(lat_seen), 32'd3);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
